// File: rtl/ram_pkg.sv
// Shared definitions for the clearable dual-port RAM: sweep states,
// read-during-write mode constants and the address-width helper.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear-sweep controller: walks a counter over every word after reset or a
// clear request, and reports busy while the sweep is running.
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int SZ = 32,
    parameter int AW = addr_width(SZ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    // Terminal compare so non-power-of-two depths stop exactly at SZ-1.
    localparam logic [AW-1:0] LAST = AW'(SZ - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram_dp_clr.sv
// Simple-dual-port RAM with per-bit write mask, selectable read-during-write
// behaviour, sticky range error and a hardware clear sweep.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int SZ  = 32,
    parameter  int RDW = 0,
    localparam int AW  = addr_width(SZ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [N-1:0]  wmask,
    input  logic          ren,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  o,
    output logic          ovalid,
    output logic          err
);

    localparam logic [AW:0] SZ_W = (AW + 1)'(SZ);

    logic [N-1:0]  mem [SZ];
    logic [AW-1:0] clr_addr;
    logic          clr_we;
    logic          waddr_ok, raddr_ok;
    logic          port_we, port_re;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic [N-1:0]  bit_we;

    ram_clr_fsm #(
        .SZ (SZ),
        .AW (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign waddr_ok = ({1'b0, waddr} < SZ_W);
    assign raddr_ok = ({1'b0, raddr} < SZ_W);
    assign port_we  = !busy && wen && waddr_ok;
    assign port_re  = !busy && ren;

    // Sweep and port writes never overlap because port access requires !busy.
    assign wr_addr = clr_we ? clr_addr : waddr;
    assign wr_data = clr_we ? '0 : wdata;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit_we
            assign bit_we[gi] = reset && (clr_we || (port_we && wmask[gi]));
        end
    endgenerate

    // Per-bit enables realise the masked merge without a read-modify-write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < N; b++) begin
            if (bit_we[b]) begin
                mem[wr_addr][b] <= wr_data[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o      <= '0;
            ovalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (port_re) begin
                ovalid <= 1'b1;
                if (!raddr_ok) begin
                    o <= '0;
                end else if (RDW == RDW_NEW && port_we && waddr == raddr) begin
                    o <= (mem[raddr] & ~wmask) | (wdata & wmask);
                end else begin
                    o <= mem[raddr];
                end
            end
            if (!busy && clr) begin
                err <= 1'b0;
            end else if (!busy && ((wen && !waddr_ok) || (ren && !raddr_ok))) begin
                err <= 1'b1;
            end
        end
    end

endmodule
